// File: rtl/traffic_light_controller.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_controller
// Purpose  : Two-way (NS / EW) intersection controller. Four-phase Moore FSM
//            with a built-in phase timer. NS is the rest direction; vehicle
//            detectors decide when a green phase ends once its minimum time
//            has elapsed.
// Ports    : clk                - system clock, rising-edge active
//            rst_n              - synchronous active-low reset
//            NS_VEHICLE_DETECT  - vehicle waiting on NS approach (level)
//            EW_VEHICLE_DETECT  - vehicle waiting on EW approach (level)
//            NS_RED/YELLOW/GREEN, EW_RED/YELLOW/GREEN - lamp drives
//            phase              - 0=NS_GO, 1=NS_WARN, 2=EW_GO, 3=EW_WARN
//            phase_timer        - cycles spent in current phase (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module traffic_light_controller #(
    parameter int NS_GREEN_TIME = 32,
    parameter int EW_GREEN_TIME = 16,
    parameter int YELLOW_TIME   = 4,
    parameter int TIMER_W       = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               NS_VEHICLE_DETECT,
    input  logic               EW_VEHICLE_DETECT,
    output logic               NS_RED,
    output logic               NS_YELLOW,
    output logic               NS_GREEN,
    output logic               EW_RED,
    output logic               EW_YELLOW,
    output logic               EW_GREEN,
    output logic [1:0]         phase,
    output logic [TIMER_W-1:0] phase_timer
);

    typedef enum logic [1:0] {
        NS_GO   = 2'd0,
        NS_WARN = 2'd1,
        EW_GO   = 2'd2,
        EW_WARN = 2'd3
    } phase_e;

    // Terminal timer value for each phase (duration minus one).
    localparam logic [TIMER_W-1:0] C_NS_LAST = TIMER_W'(NS_GREEN_TIME - 1);
    localparam logic [TIMER_W-1:0] C_EW_LAST = TIMER_W'(EW_GREEN_TIME - 1);
    localparam logic [TIMER_W-1:0] C_YL_LAST = TIMER_W'(YELLOW_TIME - 1);

    phase_e               phase_q, phase_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [TIMER_W-1:0]   last_val;
    logic                 expired;
    logic                 advance;

    // Next-state and timer logic.
    always_comb begin
        last_val = C_YL_LAST;
        advance  = 1'b0;
        phase_d  = phase_q;
        timer_d  = timer_q;

        case (phase_q)
            NS_GO:   last_val = C_NS_LAST;
            EW_GO:   last_val = C_EW_LAST;
            NS_WARN: last_val = C_YL_LAST;
            EW_WARN: last_val = C_YL_LAST;
        endcase

        expired = (timer_q == last_val);

        case (phase_q)
            // NS green is held indefinitely until EW demand appears.
            NS_GO:   advance = expired && EW_VEHICLE_DETECT;
            NS_WARN: advance = expired;
            // EW yields when NS has demand (NS wins ties) or EW demand is gone.
            EW_GO:   advance = expired && (NS_VEHICLE_DETECT || !EW_VEHICLE_DETECT);
            EW_WARN: advance = expired;
        endcase

        if (advance) begin
            phase_d = phase_e'(phase_q + 2'd1);
            timer_d = '0;
        end else if (!expired) begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= NS_GO;
            timer_q <= '0;
        end else begin
            phase_q <= phase_d;
            timer_q <= timer_d;
        end
    end

    // Lamp decode straight from the phase register; exactly one lamp per
    // direction, and the direction not in GO/WARN is always red.
    always_comb begin
        NS_RED    = 1'b0;
        NS_YELLOW = 1'b0;
        NS_GREEN  = 1'b0;
        EW_RED    = 1'b0;
        EW_YELLOW = 1'b0;
        EW_GREEN  = 1'b0;
        case (phase_q)
            NS_GO:   begin NS_GREEN  = 1'b1; EW_RED    = 1'b1; end
            NS_WARN: begin NS_YELLOW = 1'b1; EW_RED    = 1'b1; end
            EW_GO:   begin NS_RED    = 1'b1; EW_GREEN  = 1'b1; end
            EW_WARN: begin NS_RED    = 1'b1; EW_YELLOW = 1'b1; end
        endcase
    end

    assign phase       = phase_q;
    assign phase_timer = timer_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_light_controller
// Purpose  : Self-checking bench for traffic_light_controller. A behavioural
//            reference model (integer phase index + cycle count) predicts
//            phase, timer and lamps every cycle; directed scenarios also
//            check absolute cycle numbers against the intended timeline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_light_controller;

    localparam int C_NS_G = 32;
    localparam int C_EW_G = 16;
    localparam int C_YEL  = 4;
    localparam int C_TW   = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ns_det = 1'b0;
    logic            ew_det = 1'b0;
    logic            ns_r, ns_y, ns_g, ew_r, ew_y, ew_g;
    logic [1:0]      phase;
    logic [C_TW-1:0] phase_timer;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: phase index and cycles spent in it.
    int m_ph = 0;
    int m_t  = 0;
    int dur[4] = '{C_NS_G, C_YEL, C_EW_G, C_YEL};

    traffic_light_controller #(
        .NS_GREEN_TIME (C_NS_G),
        .EW_GREEN_TIME (C_EW_G),
        .YELLOW_TIME   (C_YEL),
        .TIMER_W       (C_TW)
    ) u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .NS_VEHICLE_DETECT (ns_det),
        .EW_VEHICLE_DETECT (ew_det),
        .NS_RED            (ns_r),
        .NS_YELLOW         (ns_y),
        .NS_GREEN          (ns_g),
        .EW_RED            (ew_r),
        .EW_YELLOW         (ew_y),
        .EW_GREEN          (ew_g),
        .phase             (phase),
        .phase_timer       (phase_timer)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Lamps {NS R,Y,G, EW R,Y,G} expected for a phase index.
    function automatic logic [5:0] lamps_for(input int ph);
        logic [2:0] ns, ew;
        ns = (ph == 0) ? 3'b001 : (ph == 1) ? 3'b010 : 3'b100;
        ew = (ph == 2) ? 3'b001 : (ph == 3) ? 3'b010 : 3'b100;
        return {ns, ew};
    endfunction

    // One rising edge of behaviour, straight from the phase rules.
    task automatic model_edge(input logic rn, input logic nsd, input logic ewd);
        bit done, leave;
        if (!rn) begin
            m_ph = 0;
            m_t  = 0;
        end else begin
            done = (m_t == dur[m_ph] - 1);
            if (m_ph == 0)      leave = done && ewd;
            else if (m_ph == 2) leave = done && (nsd || !ewd);
            else                leave = done;
            if (leave) begin
                m_ph = (m_ph + 1) % 4;
                m_t  = 0;
            end else if (m_t < dur[m_ph] - 1) begin
                m_t++;
            end
        end
    endtask

    // Apply inputs for one cycle, clock, then compare against the model.
    task automatic step(input logic rn, input logic nsd, input logic ewd);
        logic [2:0] nsl, ewl;
        rst_n  = rn;
        ns_det = nsd;
        ew_det = ewd;
        @(posedge clk);
        model_edge(rn, nsd, ewd);
        #1;
        nsl = {ns_r, ns_y, ns_g};
        ewl = {ew_r, ew_y, ew_g};
        check("phase", {30'd0, phase}, m_ph);
        check("timer", {27'd0, phase_timer}, m_t);
        check("lamps", {26'd0, nsl, ewl}, {26'd0, lamps_for(m_ph)});
        check("safety", {31'd0, ($countones(nsl) == 1) && ($countones(ewl) == 1)
                                && (ns_r || ew_r)}, 32'd1);
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    function automatic int full_cycle_phase(input int c);
        if (c < 32) return 0;
        if (c < 36) return 1;
        if (c < 52) return 2;
        if (c < 56) return 3;
        return 0;
    endfunction

    initial begin
        // Reset / default rest: no demand keeps NS green, timer saturates.
        do_reset(3);
        check("rst_phase", {30'd0, phase}, 32'd0);
        check("rst_timer", {27'd0, phase_timer}, 32'd0);
        for (int c = 1; c <= 100; c++) begin
            step(1'b1, 1'b0, 1'b0);
            check("rest_phase", {30'd0, phase}, 32'd0);
            check("rest_timer", {27'd0, phase_timer}, (c < 31) ? c : 31);
        end

        // Full cycle with both detectors held high from reset release.
        do_reset(3);
        for (int c = 1; c <= 60; c++) begin
            step(1'b1, 1'b1, 1'b1);
            check("full_phase", {30'd0, phase}, full_cycle_phase(c));
        end

        // EW extension: EW demand only keeps EW green; NS demand ends it.
        do_reset(3);
        for (int c = 1; c <= 70; c++) step(1'b1, 1'b0, 1'b1);
        check("ext_hold", {30'd0, phase}, 32'd2);
        for (int c = 71; c <= 76; c++) begin
            step(1'b1, 1'b1, 1'b1);
            check("ext_phase", {30'd0, phase}, (c <= 74) ? 32'd3 : 32'd0);
        end

        // Late demand: pulse at cycle 10 ignored, pulse at cycle 50 honoured.
        do_reset(3);
        for (int c = 0; c <= 50; c++) begin
            step(1'b1, 1'b0, (c == 10 || c == 50));
            check("late_phase", {30'd0, phase}, (c + 1 >= 51) ? 32'd1 : 32'd0);
        end

        // Mid-phase reset during EW green.
        do_reset(3);
        for (int c = 1; c <= 40; c++) step(1'b1, 1'b1, 1'b1);
        check("mid_pre", {30'd0, phase}, 32'd2);
        step(1'b0, 1'b1, 1'b1);
        check("mid_phase", {30'd0, phase}, 32'd0);
        check("mid_timer", {27'd0, phase_timer}, 32'd0);
        check("mid_lamps", {30'd0, ns_g, ew_r}, 32'd3);

        // Randomised detectors, with slowly varying bias to reach every phase.
        do_reset(2);
        for (int i = 0; i < 1000; i++) begin
            int bias;
            bias = (i / 100) % 4;
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 3) < bias),
                 ($urandom_range(0, 3) >= bias));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/traffic_light_controller.md
Name: traffic_light_controller

Overview:
- Two-way intersection controller: north-south (NS) and east-west (EW) lamp sets, each red/yellow/green.
- The phase timers are built in; they replace separate per-direction counters.
- Moore FSM with four phases. NS is the default (rest) direction. Vehicle-detector inputs decide when a green phase ends after its minimum time.
- Sits between the detector front-end and the lamp drivers.

Parameters:
- NS_GREEN_TIME, 32, minimum NS green duration in clock cycles (>=1).
- EW_GREEN_TIME, 16, minimum EW green duration in clock cycles (>=1).
- YELLOW_TIME, 4, yellow duration in clock cycles for either direction (>=1).
- TIMER_W, 5, phase timer width; must satisfy 2**TIMER_W >= max(NS_GREEN_TIME, EW_GREEN_TIME, YELLOW_TIME).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- NS_VEHICLE_DETECT  input  1  vehicle waiting on NS approach (level, sampled on clk).
- EW_VEHICLE_DETECT  input  1  vehicle waiting on EW approach (level, sampled on clk).
- NS_RED  output  1  NS red lamp.
- NS_YELLOW  output  1  NS yellow lamp.
- NS_GREEN  output  1  NS green lamp.
- EW_RED  output  1  EW red lamp.
- EW_YELLOW  output  1  EW yellow lamp.
- EW_GREEN  output  1  EW green lamp.
- phase  output  2  current phase: 0=NS_GO, 1=NS_WARN, 2=EW_GO, 3=EW_WARN.
- phase_timer  output  TIMER_W  cycles spent in current phase (0-based, saturating).

Behaviour:
- Reset: on a rising edge with rst_n=0, phase=NS_GO and phase_timer=0. Reset has priority over everything, including mid-phase.
- Lamp decode (combinational from the phase register only):
  - NS_GO: NS_GREEN=1, EW_RED=1.
  - NS_WARN: NS_YELLOW=1, EW_RED=1.
  - EW_GO: NS_RED=1, EW_GREEN=1.
  - EW_WARN: NS_RED=1, EW_YELLOW=1.
  - All other lamps are 0. Exactly one lamp per direction is on; at least one direction is always red.
- Timer:
  - Increments by 1 each cycle while the phase holds.
  - Saturates at T-1, where T is the current phase's duration parameter.
  - Clears to 0 on every phase transition.
- A phase "expires" when phase_timer == T-1.
- Transitions, evaluated each rising edge with rst_n=1:
  - NS_GO -> NS_WARN when expired AND EW_VEHICLE_DETECT=1. Otherwise hold; NS green is extended indefinitely.
  - NS_WARN -> EW_GO when expired (unconditional).
  - EW_GO -> EW_WARN when expired AND (NS_VEHICLE_DETECT=1 OR EW_VEHICLE_DETECT=0). Otherwise hold.
  - EW_WARN -> NS_GO when expired (unconditional).
- Detectors are ignored before expiry; a pulse that ends before expiry has no effect.
- Both detectors high at NS_GO expiry: go to NS_WARN. Both high at EW_GO expiry: go to EW_WARN, so NS wins the tie.
- Timing, with cycle 0 = first cycle after rst_n rises:
  - NS green for cycles 0..NS_GREEN_TIME-1 minimum.
  - Yellow for exactly YELLOW_TIME cycles.
  - EW green for EW_GREEN_TIME cycles minimum.
- The lamp change is visible in the cycle after the qualifying edge; there is no extra output register.
- All four phase encodings are legal; there is no unreachable state.

Test Plan:
- Reset/default: rst_n=0 for 3 cycles, then both detectors 0 for 100 cycles -> phase=0, NS_GREEN=1, EW_RED=1 throughout; phase_timer saturates at 31.
- Full cycle: EW_VEHICLE_DETECT=1, NS_VEHICLE_DETECT=1 from reset release -> NS green cycles 0-31, NS yellow 32-35, EW green 36-51, EW yellow 52-55, NS green from 56.
- EW extension: reach EW_GO with EW_VEHICLE_DETECT=1 and NS_VEHICLE_DETECT=0 held -> EW green persists past 16 cycles. Raise NS_VEHICLE_DETECT -> EW_YELLOW on the next cycle, for 4 cycles, then NS_GREEN.
- Late demand: keep EW detect 0 until cycle 50, then pulse it high for 1 cycle -> NS_YELLOW at cycle 51. A 1-cycle pulse at cycle 10 only -> no phase change.
- Mid-phase reset: assert rst_n=0 for 1 cycle during EW_GO -> next cycle phase=0, phase_timer=0, NS_GREEN=1, EW_RED=1.
- Safety check every cycle of random detector stimulus (1000 cycles): exactly one lamp per direction; never NS non-red while EW non-red.
